pc_sequencer: RTL and testbench

Fetch-stage program-counter sequencer. Owns the PC register, issues instruction fetch addresses to instruction memory over a valid/ready handshake, and applies branch and jump redirects from execute. Drives the 2-bit next-PC select encoding ({s1=branch, s0=jump}: 00 PC+4, 01 jump, 10/11 branch) and a flush pulse to the decode stage.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sel_mux.sv | 26 ++
 rtl/pc_sequencer.sv | 150 +++++++++++++++
 tb/tb_pc_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage PC sequencer.
//   state_e         sequencer states (RST, FETCH, WAIT, REDIR)
//   SEL_*           next-PC select encoding {s1=branch, s0=jump}
//   PC_STEP_DEFAULT default sequential increment in bytes
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_REDIR = 2'd3
    } state_e;

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_JUMP   = 2'b01;
    localparam logic [1:0] SEL_BRANCH = 2'b10;

    localparam int unsigned PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/pc_sel_mux.sv
// pc_sel_mux: 4-way 32-bit next-PC selector.
//   sel_i     {s1=branch, s0=jump}: 00 seq, 01 jump, 10/11 branch
//   seq_i     PC + step
//   jump_i    jump target
//   branch_i  branch target
//   pc_o      selected next PC
module pc_sel_mux
    import pc_seq_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [31:0] seq_i,
    input  logic [31:0] jump_i,
    input  logic [31:0] branch_i,
    output logic [31:0] pc_o
);

    always_comb begin
        pc_o = seq_i;
        unique case (sel_i)
            SEL_SEQ:  pc_o = seq_i;
            SEL_JUMP: pc_o = jump_i;
            default:  pc_o = branch_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program-counter sequencer.
// Owns the PC, issues fetch addresses over a valid/ready handshake and
// applies branch/jump redirects from execute.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall_i               hazard hold, PC does not advance
//   imem_ready_i          instruction memory accepts current fetch
//   fetch_valid_o/addr_o  fetch request and address (current PC)
//   pc_plus4_o            fetch address + PC_STEP
//   br_taken_i/target_i   branch redirect
//   jump_i/jump_target_i  jump redirect
//   sel_o                 next-PC source applied this cycle
//   flush_o               one-cycle pulse in the redirect bubble
//   misalign_o            misaligned redirect target pulse
// Configuration: define PC_MISALIGN_TRAP_EN to enable misalign_o detection;
// otherwise misalign_o is tied low.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        imem_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_addr_o,
    output logic [31:0] pc_plus4_o,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    output logic [1:0]  sel_o,
    output logic        flush_o,
    output logic        misalign_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]  pend_sel_q, pend_sel_d;

    logic [31:0] pc_seq, mux_out, jump_in, branch_in;
    logic        redir_new, redir_apply;
    logic [1:0]  new_sel;
    logic [31:0] new_tgt;

    assign pc_seq    = pc_q + 32'(PC_STEP);
    assign redir_new = br_taken_i | jump_i;
    assign new_sel   = br_taken_i ? SEL_BRANCH : SEL_JUMP;
    assign new_tgt   = br_taken_i ? br_target_i : jump_target_i;

    // A fresh redirect feeds the mux directly; otherwise both target legs
    // carry the pending target so the stored select picks it either way.
    assign jump_in   = jump_i     ? jump_target_i : pend_tgt_q;
    assign branch_in = br_taken_i ? br_target_i   : pend_tgt_q;

    pc_sel_mux u_mux (
        .sel_i    (sel_o),
        .seq_i    (pc_seq),
        .jump_i   (jump_in),
        .branch_i (branch_in),
        .pc_o     (mux_out)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_d        = pend_q;
        pend_tgt_d    = pend_tgt_q;
        pend_sel_d    = pend_sel_q;
        sel_o         = SEL_SEQ;
        redir_apply   = 1'b0;
        fetch_valid_o = 1'b0;

        unique case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                fetch_valid_o = 1'b1;
                if (redir_new) begin
                    if (imem_ready_i) begin
                        sel_o       = new_sel;
                        redir_apply = 1'b1;
                        state_d     = ST_REDIR;
                    end else begin
                        pend_d     = 1'b1;
                        pend_tgt_d = new_tgt;
                        pend_sel_d = new_sel;
                        state_d    = ST_WAIT;
                    end
                end else if (!imem_ready_i) begin
                    state_d = ST_WAIT;
                end else if (!stall_i) begin
                    pc_d = mux_out;
                end
            end
            ST_WAIT: begin
                fetch_valid_o = 1'b1;
                if (imem_ready_i) begin
                    pend_d = 1'b0;
                    if (redir_new || pend_q) begin
                        sel_o       = redir_new ? new_sel : pend_sel_q;
                        redir_apply = 1'b1;
                        state_d     = ST_REDIR;
                    end else begin
                        state_d = ST_FETCH;
                        if (!stall_i) pc_d = mux_out;
                    end
                end else if (redir_new) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = new_tgt;
                    pend_sel_d = new_sel;
                end
            end
            ST_REDIR: state_d = ST_FETCH;
            default:  state_d = ST_RST;
        endcase

        if (redir_apply) pc_d = {mux_out[31:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            pend_sel_q <= SEL_SEQ;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            pend_sel_q <= pend_sel_d;
        end
    end

    assign fetch_addr_o = pc_q;
    assign pc_plus4_o   = pc_seq;
    assign flush_o      = (state_q == ST_REDIR);

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o = redir_apply & (|mux_out[1:0]);
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, imem_ready_i, br_taken_i, jump_i;
    logic [31:0] br_target_i, jump_target_i;
    logic        fetch_valid_o, flush_o, misalign_o;
    logic [31:0] fetch_addr_o, pc_plus4_o;
    logic [1:0]  sel_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .imem_ready_i  (imem_ready_i),
        .fetch_valid_o (fetch_valid_o),
        .fetch_addr_o  (fetch_addr_o),
        .pc_plus4_o    (pc_plus4_o),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .jump_i        (jump_i),
        .jump_target_i (jump_target_i),
        .sel_o         (sel_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    typedef struct {
        logic        stall, rdy, br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        ev;
        logic [31:0] ea;
        logic [1:0]  es;
        logic        ef, em;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic stall, logic rdy, logic br, logic [31:0] brt,
                                logic j, logic [31:0] jt, logic ev, logic [31:0] ea,
                                logic [1:0] es, logic ef, logic em);
        vec_t v;
        v.stall = stall; v.rdy = rdy; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
        v.ev = ev; v.ea = ea; v.es = es; v.ef = ef; v.em = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] ea,
                             input logic [1:0] es, input logic ef, input logic em);
        check({tag, " valid"}, 32'(fetch_valid_o), 32'(ev));
        check({tag, " addr"},  fetch_addr_o, ea);
        check({tag, " plus4"}, pc_plus4_o, ea + 32'd4);
        check({tag, " sel"},   32'(sel_o), 32'(es));
        check({tag, " flush"}, 32'(flush_o), 32'(ef));
        check({tag, " mis"},   32'(misalign_o), 32'(em));
    endtask

    task automatic drive(input logic stall, input logic rdy, input logic br, input logic [31:0] brt,
                         input logic j, input logic [31:0] jt);
        stall_i = stall; imem_ready_i = rdy; br_taken_i = br; br_target_i = brt;
        jump_i = j; jump_target_i = jt;
    endtask

    initial begin
        // stall rdy br brt j jt | valid addr sel flush mis
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h0,2'b00,0,0));   // RST state
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h0,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h4,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h8,2'b00,0,0));
        vecs.push_back(mk(0,1,1,32'h100,1,32'h200,          1,32'hC,2'b10,0,0));   // branch wins
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h100,2'b00,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h100,2'b00,0,0));
        vecs.push_back(mk(1,1,0,0,0,0,                      1,32'h104,2'b00,0,0)); // stall
        vecs.push_back(mk(1,1,0,0,0,0,                      1,32'h104,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h104,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'h40,                 1,32'h108,2'b01,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h40,2'b00,1,0));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h40,2'b00,0,0));  // -> WAIT
        vecs.push_back(mk(0,0,0,0,1,32'h80,                 1,32'h40,2'b00,0,0));  // latched
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h40,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h40,2'b01,0,0));  // pending applied
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h80,2'b00,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h80,2'b00,0,0));
        vecs.push_back(mk(0,0,1,32'h200,0,0,                1,32'h84,2'b00,0,0));  // pending branch
        vecs.push_back(mk(0,0,0,0,1,32'h300,                1,32'h84,2'b00,0,0));  // overwritten
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h84,2'b01,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h300,2'b00,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h300,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,1,32'hFFFF_FFFC,          1,32'h304,2'b01,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'hFFFF_FFFC,2'b00,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'hFFFF_FFFC,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h0,2'b00,0,0));   // wrapped
        vecs.push_back(mk(0,1,0,0,1,32'h102,                1,32'h4,2'b01,0,MIS_EN));
        vecs.push_back(mk(0,1,0,0,0,0,                      0,32'h100,2'b00,1,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h100,2'b00,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                      1,32'h104,2'b00,0,0)); // WAIT no pending
        vecs.push_back(mk(1,1,0,0,0,0,                      1,32'h104,2'b00,0,0)); // ready+stall
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h104,2'b00,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,                      1,32'h108,2'b00,0,0));

        rst_n = 1'b0;
        drive(0, 1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 check_all("reset", 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].rdy, vecs[i].br, vecs[i].brt, vecs[i].j, vecs[i].jt);
            #1 check_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].es, vecs[i].ef, vecs[i].em);
            @(negedge clk);
        end

        // PC now 0x10C in FETCH: enter WAIT with a pending jump, then reset mid-cycle.
        drive(0, 0, 0, 0, 1, 32'h500);
        #1 check_all("wait_in", 1'b1, 32'h10C, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0);
        #1 check_all("wait_hold", 1'b1, 32'h10C, 2'b00, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_all("rst_mid", 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 check_all("rel_rst", 1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #1 check_all("rel_f0", 1'b1, 32'h0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        #1 check_all("rel_f4", 1'b1, 32'h4, 2'b00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
